// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory arbiter
package imem_arb_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_FETCH, OWN_LOADER} owner_t;
  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; index 0 is fetch, index 1 is loader
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last_l;
  always_comb begin
    gnt[0] = req[0] & (~req[1] | last_l);
    gnt[1] = req[1] & ~gnt[0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_l <= 1'b1;
    else if (advance) last_l <= gnt[1];
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a fixed-latency single-port instruction memory between fetch and loader
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_req,
  input  logic [AW-1:0]            f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [DW-1:0]            f_rdata,
  input  logic                     l_req,
  input  logic                     l_we,
  input  logic [AW-1:0]            l_addr,
  input  logic [DW-1:0]            l_wdata,
  output logic                     l_gnt,
  output logic                     l_rvalid,
  output logic [DW-1:0]            l_rdata,
  output logic                     m_en,
  output logic                     m_we,
  output logic [AW-WORD_SHIFT-1:0] m_addr,
  output logic [DW-1:0]            m_wdata,
  input  logic [DW-1:0]            m_rdata,
  output logic                     busy
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t          state, state_nx;
  owner_t          owner;
  logic            pend, we_q, resp, can_grant, grant;
  logic [CW-1:0]   cnt;
  logic [1:0]      gnt;
  logic            unused_lsb;
  assign unused_lsb = ^{f_addr[WORD_SHIFT-1:0], l_addr[WORD_SHIFT-1:0]};
  assign resp = pend && cnt == '0;
  // reset also gates grants so every output is quiet while reset is held
  assign can_grant = reset && (state == IDLE || resp);
  assign grant = |gnt;
  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({l_req, f_req} & {2{can_grant}}),
    .advance (grant),
    .gnt     (gnt)
  );
  always_comb begin
    state_nx = grant ? (LATENCY > 1 ? WAIT : IDLE) : resp ? IDLE : state;
    f_gnt    = gnt[0];
    l_gnt    = gnt[1];
    m_en     = grant;
    m_we     = gnt[1] & l_we;
    m_addr   = gnt[1] ? l_addr[AW-1:WORD_SHIFT] : gnt[0] ? f_addr[AW-1:WORD_SHIFT] : '0;
    m_wdata  = m_we ? l_wdata : '0;
    f_rvalid = resp && owner == OWN_FETCH;
    l_rvalid = resp && owner == OWN_LOADER;
    f_rdata  = f_rvalid ? m_rdata : '0;
    l_rdata  = (l_rvalid && !we_q) ? m_rdata : '0;
    busy     = pend;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      owner <= OWN_FETCH;
      we_q  <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= grant | (pend & ~resp);
      cnt   <= grant ? CW'(LATENCY - 1) : cnt != '0 ? cnt - CW'(1) : cnt;
      if (grant) begin
        owner <= gnt[1] ? OWN_LOADER : OWN_FETCH;
        we_q  <= gnt[1] & l_we;
      end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: vector table, directed corner sequences and a random run against a cycle-level model
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic        f_req = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0;
  logic        f_gnt_a, f_rvalid_a, l_gnt_a, l_rvalid_a, m_en_a, m_we_a, busy_a;
  logic [31:0] f_rdata_a, l_rdata_a, m_wdata_a, m_rdata_a;
  logic [29:0] m_addr_a;
  logic        f_gnt_b, f_rvalid_b, l_gnt_b, l_rvalid_b, m_en_b, m_we_b, busy_b;
  logic [31:0] f_rdata_b, l_rdata_b, m_wdata_b, m_rdata_b;
  logic [29:0] m_addr_b;
  imem_arbiter #(.AW(32), .DW(32), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_a),
    .f_rvalid(f_rvalid_a), .f_rdata(f_rdata_a), .l_req(l_req), .l_we(l_we),
    .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt_a), .l_rvalid(l_rvalid_a),
    .l_rdata(l_rdata_a), .m_en(m_en_a), .m_we(m_we_a), .m_addr(m_addr_a),
    .m_wdata(m_wdata_a), .m_rdata(m_rdata_a), .busy(busy_a));
  imem_arbiter #(.AW(32), .DW(32), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt_b),
    .f_rvalid(f_rvalid_b), .f_rdata(f_rdata_b), .l_req(l_req), .l_we(l_we),
    .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt_b), .l_rvalid(l_rvalid_b),
    .l_rdata(l_rdata_b), .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b),
    .m_wdata(m_wdata_b), .m_rdata(m_rdata_b), .busy(busy_b));

  function automatic logic [31:0] init_word(int i);
    return i == 2 ? 32'h00500093 : 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // memory models: contents reload while reset is held, read data appears LATENCY cycles after m_en
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pa0 = '0, pa1 = '0, pb0 = '0;
  assign m_rdata_a = pa1;
  assign m_rdata_b = pb0;
  always @(posedge clk) begin
    if (!reset) for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    else if (m_en_a && m_we_a) mem_a[m_addr_a[7:0]] <= m_wdata_a;
    pa0 <= m_en_a ? mem_a[m_addr_a[7:0]] : '0;
    pa1 <= pa0;
  end
  always @(posedge clk) begin
    if (!reset) for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
    else if (m_en_b && m_we_b) mem_b[m_addr_b[7:0]] <= m_wdata_b;
    pb0 <= m_en_b ? mem_b[m_addr_b[7:0]] : '0;
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    f_req = 1'b0;
    l_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic fr; logic [31:0] fa; logic lr, lw; logic [31:0] la, ld;
    logic fg, lg, we; logic [29:0] ma;
    logic frv; logic [31:0] frd; logic lrv; logic [31:0] lrd; logic bsy;
  } vec_t;
  vec_t tbl [13];
  function automatic vec_t v(logic fr, logic [31:0] fa, logic lr, logic lw, logic [31:0] la,
                             logic [31:0] ld, logic fg, logic lg, logic we, logic [29:0] ma,
                             logic frv, logic [31:0] frd, logic lrv, logic [31:0] lrd, logic bsy);
    v = '{fr, fa, lr, lw, la, ld, fg, lg, we, ma, frv, frd, lrv, lrd, bsy};
  endfunction

  typedef struct { int t; bit own_l; logic [31:0] d; } resp_t;
  resp_t rq [$];
  logic [31:0] ref_mem [256];

  initial begin
    bit fg, lg, erv_f, erv_l, outst, last_l, free;
    int gc;
    logic [31:0] erd;
    tbl[0]  = v(1, 32'h8,  0, 0, 0,     0,            1, 0, 0, 2, 0, 0,            0, 0,            0);
    tbl[1]  = v(0, 0,      0, 0, 0,     0,            0, 0, 0, 0, 0, 0,            0, 0,            1);
    tbl[2]  = v(0, 0,      1, 1, 32'h10, 32'hDEADBEEF, 0, 1, 1, 4, 1, 32'h00500093, 0, 0,            1);
    tbl[3]  = v(1, 32'h10, 0, 0, 0,     0,            0, 0, 0, 0, 0, 0,            0, 0,            1);
    tbl[4]  = v(1, 32'h10, 0, 0, 0,     0,            1, 0, 0, 4, 0, 0,            1, 0,            1);
    tbl[5]  = v(0, 0,      0, 0, 0,     0,            0, 0, 0, 0, 0, 0,            0, 0,            1);
    tbl[6]  = v(0, 0,      0, 0, 0,     0,            0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0,            1);
    tbl[7]  = v(0, 0,      0, 0, 0,     0,            0, 0, 0, 0, 0, 0,            0, 0,            0);
    tbl[8]  = v(1, 32'h8,  1, 0, 32'h10, 0,           0, 1, 0, 4, 0, 0,            0, 0,            0);
    tbl[9]  = v(1, 32'h8,  1, 0, 32'h10, 0,           0, 0, 0, 0, 0, 0,            0, 0,            1);
    tbl[10] = v(1, 32'h8,  1, 0, 32'h10, 0,           1, 0, 0, 2, 0, 0,            1, 32'hDEADBEEF, 1);
    tbl[11] = v(1, 32'h8,  1, 0, 32'h10, 0,           0, 0, 0, 0, 0, 0,            0, 0,            1);
    tbl[12] = v(1, 32'h8,  1, 0, 32'h10, 0,           0, 1, 0, 4, 1, 32'h00500093, 0, 0,            1);

    // requests held high during reset must not leak to any output
    f_req = 1'b1;
    l_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_a", {f_gnt_a, l_gnt_a, m_en_a, m_we_a, f_rvalid_a, l_rvalid_a, busy_a,
                        |m_addr_a, |m_wdata_a, |f_rdata_a, |l_rdata_a}, 0);
    chk("reset_out_b", {f_gnt_b, l_gnt_b, m_en_b, m_we_b, f_rvalid_b, l_rvalid_b, busy_b,
                        |m_addr_b, |m_wdata_b, |f_rdata_b, |l_rdata_b}, 0);
    reset = 1'b1;
    f_req = 1'b0;
    l_req = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      f_req = tbl[i].fr; f_addr = tbl[i].fa;
      l_req = tbl[i].lr; l_we = tbl[i].lw; l_addr = tbl[i].la; l_wdata = tbl[i].ld;
      @(negedge clk);
      chk($sformatf("tbl%0d.f_gnt", i), f_gnt_a, tbl[i].fg);
      chk($sformatf("tbl%0d.l_gnt", i), l_gnt_a, tbl[i].lg);
      chk($sformatf("tbl%0d.m_en", i), m_en_a, tbl[i].fg | tbl[i].lg);
      chk($sformatf("tbl%0d.m_we", i), m_we_a, tbl[i].we);
      if (tbl[i].fg | tbl[i].lg) chk($sformatf("tbl%0d.m_addr", i), m_addr_a, tbl[i].ma);
      if (tbl[i].we) chk($sformatf("tbl%0d.m_wdata", i), m_wdata_a, tbl[i].ld);
      chk($sformatf("tbl%0d.f_rvalid", i), f_rvalid_a, tbl[i].frv);
      chk($sformatf("tbl%0d.f_rdata", i), f_rdata_a, tbl[i].frd);
      chk($sformatf("tbl%0d.l_rvalid", i), l_rvalid_a, tbl[i].lrv);
      chk($sformatf("tbl%0d.l_rdata", i), l_rdata_a, tbl[i].lrd);
      chk($sformatf("tbl%0d.busy", i), busy_a, tbl[i].bsy);
      @(posedge clk);
      #1;
    end

    // saturated requesters from reset: F, L, F, L every second cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      f_req = 1'b1; f_addr = 32'h8; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
      @(negedge clk);
      chk($sformatf("tie%0d.f_gnt", k), f_gnt_a, k % 4 == 0);
      chk($sformatf("tie%0d.l_gnt", k), l_gnt_a, k % 4 == 2);
      chk($sformatf("tie%0d.two_gnt", k), f_gnt_a & l_gnt_a, 0);
      chk($sformatf("tie%0d.gnt_busy", k), (f_gnt_a | l_gnt_a) & busy_a & ~(f_rvalid_a | l_rvalid_a), 0);
      chk($sformatf("tie%0d.busy", k), busy_a, k != 0);
      chk($sformatf("tie%0d.f_rdata", k), f_rdata_a, (k == 2 || k == 6) ? init_word(2) : 0);
      chk($sformatf("tie%0d.l_rdata", k), l_rdata_a, k == 4 ? init_word(4) : 0);
      chk($sformatf("tie%0d.rvalid", k), {f_rvalid_a, l_rvalid_a}, (k == 2 || k == 6) ? 2'b10 : k == 4 ? 2'b01 : 2'b00);
      @(posedge clk);
      #1;
    end

    // reset in the cycle after a grant aborts the access and restores fetch priority
    do_reset();
    f_req = 1'b1; f_addr = 32'h8; l_req = 1'b0;
    @(negedge clk);
    chk("abort.grant", f_gnt_a, 1);
    @(posedge clk);
    #1;
    l_req = 1'b1;
    reset = 1'b0;
    #1;
    chk("abort.out_zero", {f_gnt_a, l_gnt_a, m_en_a, m_we_a, f_rvalid_a, l_rvalid_a, busy_a,
                           |m_addr_a, |m_wdata_a, |f_rdata_a, |l_rdata_a}, 0);
    @(negedge clk);
    reset = 1'b1;
    f_req = 1'b0;
    l_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort.quiet%0d", k), {f_rvalid_a, l_rvalid_a, busy_a}, 0);
    end
    @(posedge clk);
    #1;
    f_req = 1'b1; l_req = 1'b1;
    @(negedge clk);
    chk("abort.tie_gnt", {f_gnt_a, l_gnt_a}, 2'b10);

    // LATENCY=1: grants every cycle, data one cycle later in order
    do_reset();
    for (int k = 0; k < 4; k++) begin
      f_req = k < 3; f_addr = 32'(4 * k);
      @(negedge clk);
      chk($sformatf("lat1_%0d.f_gnt", k), f_gnt_b, k < 3);
      if (k < 3) chk($sformatf("lat1_%0d.m_addr", k), m_addr_b, k);
      chk($sformatf("lat1_%0d.f_rvalid", k), f_rvalid_b, k > 0);
      chk($sformatf("lat1_%0d.f_rdata", k), f_rdata_b, k > 0 ? init_word(k - 1) : 0);
      chk($sformatf("lat1_%0d.busy", k), busy_b, k > 0);
      @(posedge clk);
      #1;
    end

    // random traffic against a cycle-count reference model
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    outst = 0; last_l = 1; gc = 0; fg = 0; lg = 0;
    rq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (fg || !f_req) begin
        f_req = 1'($urandom_range(1)); f_addr = 32'($urandom_range(1023));
      end else if ($urandom_range(15) == 0) f_req = 1'b0;
      if (lg || !l_req) begin
        l_req = 1'($urandom_range(1)); l_we = 1'($urandom_range(1));
        l_addr = 32'($urandom_range(1023)); l_wdata = $urandom;
      end else if ($urandom_range(15) == 0) l_req = 1'b0;
      @(negedge clk);
      free = !outst || cyc >= gc + 2;
      fg = free && f_req && (!l_req || last_l);
      lg = free && l_req && !fg;
      erv_f = 0; erv_l = 0; erd = 0;
      if (rq.size() > 0 && rq[0].t == cyc) begin
        erv_f = !rq[0].own_l; erv_l = rq[0].own_l; erd = rq[0].d;
        void'(rq.pop_front());
      end
      chk($sformatf("rnd%0d.gnt", cyc), {f_gnt_a, l_gnt_a, m_en_a}, {fg, lg, fg | lg});
      chk($sformatf("rnd%0d.m_we", cyc), m_we_a, lg && l_we);
      if (fg || lg) chk($sformatf("rnd%0d.m_addr", cyc), m_addr_a, (lg ? l_addr : f_addr) >> 2);
      if (lg && l_we) chk($sformatf("rnd%0d.m_wdata", cyc), m_wdata_a, l_wdata);
      chk($sformatf("rnd%0d.rvalid", cyc), {f_rvalid_a, l_rvalid_a}, {erv_f, erv_l});
      chk($sformatf("rnd%0d.f_rdata", cyc), f_rdata_a, erv_f ? erd : 0);
      chk($sformatf("rnd%0d.l_rdata", cyc), l_rdata_a, erv_l ? erd : 0);
      chk($sformatf("rnd%0d.busy", cyc), busy_a, outst && cyc > gc && cyc <= gc + 2);
      if (fg || lg) begin
        rq.push_back('{cyc + 2, lg, lg ? (l_we ? 32'h0 : ref_mem[l_addr[9:2]]) : ref_mem[f_addr[9:2]]});
        if (lg && l_we) ref_mem[l_addr[9:2]] = l_wdata;
        outst = 1; gc = cyc; last_l = lg;
      end
      @(posedge clk);
      #1;
    end
    f_req = 1'b0;
    l_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
